// File: rtl/csa_pkg.sv
// Shared types and elaboration helpers for the carry-save accumulator.
// csa_levels gives the depth of the 3:2 reduction tree for a given row count.
package csa_pkg;

  localparam int CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCUM   = 2'd1,
    RESOLVE = 2'd2,
    OUTPUT  = 2'd3
  } state_t;

  // Rows left after lvl stages: each stage turns every full group of 3 into 2.
  function automatic int csa_rows_at(input int n, input int lvl);
    int r;
    r = n;
    for (int i = 0; i < lvl; i++) r = r - r / 3;
    return r;
  endfunction

  function automatic int csa_levels(input int n);
    int r;
    int l;
    r = n;
    l = 0;
    while (r > 2) begin
      r = r - r / 3;
      l++;
    end
    return l;
  endfunction

endpackage

// File: rtl/csa_accumulator_csa_3to2.sv
// Vector 3:2 compressor: per-bit full adder without carry propagation.
module csa_3to2 #(
  parameter int W = 40
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] c,
  output logic [W-1:0] s,
  output logic [W-1:0] co
);

  assign s  = a ^ b ^ c;
  assign co = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/csa_accumulator.sv
// Multi-operand carry-save accumulator: beats fold into a redundant (sum, carry)
// pair through a Wallace-style 3:2 tree; one carry-propagate add per packet.
module csa_accumulator
  import csa_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int NUM_OPS = 3,
  parameter int ACC_W   = 40
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [NUM_OPS*WIDTH-1:0] in_ops,
  input  logic                     in_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ACC_W-1:0]         out_sum,
  output logic [CNT_W-1:0]         out_count,
  output logic                     out_ovf,
  output state_t                   dbg_state
);

  // Handshakes: a beat transfers on a rising edge where in_valid & in_ready;
  // the result transfers where out_valid & out_ready. Neither valid may be
  // withdrawn by its source until the transfer edge.

  localparam int NROWS  = NUM_OPS + 2;
  localparam int LEVELS = csa_levels(NROWS);

  state_t             state;
  logic [ACC_W-1:0]   sum_q;
  logic [ACC_W-1:0]   carry_q;
  logic [CNT_W-1:0]   count;
  logic               ovf;
  logic               accept;
  logic [ACC_W-1:0]   rows [0:LEVELS-1][0:NROWS-1];
  logic               drop [0:LEVELS-1][0:NROWS-1];
  logic [ACC_W-1:0]   fin_s;
  logic [ACC_W-1:0]   fin_c;
  logic               tree_ovf;
  logic [ACC_W:0]     resolved;

  assign in_ready  = (state == IDLE) || (state == ACCUM);
  assign accept    = in_valid & in_ready;
  assign dbg_state = state;

  genvar k, lvl, slot;
  generate
    for (k = 0; k < NUM_OPS; k++) begin : g_in
      assign rows[0][k] = ACC_W'(in_ops[k*WIDTH +: WIDTH]);
    end
  endgenerate
  assign rows[0][NUM_OPS]   = sum_q;
  assign rows[0][NUM_OPS+1] = {carry_q[ACC_W-2:0], 1'b0};

  generate
    for (lvl = 0; lvl < LEVELS; lvl++) begin : g_lvl
      localparam int N = csa_rows_at(NROWS, lvl);
      localparam int G = N / 3;
      for (slot = 0; slot < NROWS; slot++) begin : g_slot
        if (slot < G) begin : g_csa
          logic [ACC_W-1:0] s;
          logic [ACC_W-1:0] co;
          csa_3to2 #(.W(ACC_W)) u_csa (
            .a (rows[lvl][3*slot]),
            .b (rows[lvl][3*slot+1]),
            .c (rows[lvl][3*slot+2]),
            .s (s),
            .co(co)
          );
          if (lvl == LEVELS - 1) begin : g_final
            // The last carry row is kept unshifted; its weight-2 is applied at resolve.
            assign fin_s          = s;
            assign fin_c          = co;
            assign drop[lvl][slot] = 1'b0;
          end else begin : g_mid
            assign rows[lvl+1][2*slot]   = s;
            assign rows[lvl+1][2*slot+1] = {co[ACC_W-2:0], 1'b0};
            assign drop[lvl][slot]       = co[ACC_W-1];
          end
        end else begin : g_nocsa
          assign drop[lvl][slot] = 1'b0;
        end
        if (lvl < LEVELS - 1) begin : g_next
          if (slot >= 2*G && slot < 2*G + N%3) begin : g_pass
            assign rows[lvl+1][slot] = rows[lvl][G+slot];
          end else if (slot >= 2*G + N%3) begin : g_zero
            assign rows[lvl+1][slot] = '0;
          end
        end
      end
    end
  endgenerate

  // Any bit pushed past the MSB means the true total already reached 2^ACC_W.
  always_comb begin
    tree_ovf = carry_q[ACC_W-1];
    for (int l = 0; l < LEVELS; l++)
      for (int i = 0; i < NROWS; i++)
        tree_ovf = tree_ovf | drop[l][i];
  end

  assign resolved = {1'b0, sum_q} + {carry_q, 1'b0};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      sum_q     <= '0;
      carry_q   <= '0;
      count     <= '0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_count <= '0;
      out_ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE, ACCUM: begin
          if (accept) begin
            sum_q   <= fin_s;
            carry_q <= fin_c;
            ovf     <= ovf | tree_ovf;
            if (count != {CNT_W{1'b1}}) count <= count + 1'b1;
            state   <= in_last ? RESOLVE : ACCUM;
          end
        end
        RESOLVE: begin
          out_sum   <= resolved[ACC_W-1:0];
          out_ovf   <= ovf | resolved[ACC_W] | carry_q[ACC_W-1];
          out_count <= count;
          out_valid <= 1'b1;
          state     <= OUTPUT;
        end
        OUTPUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            sum_q     <= '0;
            carry_q   <= '0;
            count     <= '0;
            ovf       <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_csa_accumulator.sv
// Directed bench for csa_accumulator: a table of single-beat packets plus
// hand-written multi-beat, backpressure, reset and narrow-accumulator sequences.
module tb_csa_accumulator;
  import csa_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_last, out_ready;
  logic [95:0] in_ops;
  logic        in_ready, out_valid, out_ovf;
  logic [39:0] out_sum;
  logic [15:0] out_count;
  state_t      dbg_state;

  logic        in_valid33, in_last33, out_ready33;
  logic [95:0] in_ops33;
  logic        in_ready33, out_valid33, out_ovf33;
  logic [32:0] out_sum33;
  logic [15:0] out_count33;
  state_t      dbg_state33;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  csa_accumulator #(.WIDTH(32), .NUM_OPS(3), .ACC_W(40)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_ops(in_ops), .in_last(in_last), .out_valid(out_valid),
    .out_ready(out_ready), .out_sum(out_sum), .out_count(out_count),
    .out_ovf(out_ovf), .dbg_state(dbg_state)
  );

  csa_accumulator #(.WIDTH(32), .NUM_OPS(3), .ACC_W(33)) dut33 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid33), .in_ready(in_ready33),
    .in_ops(in_ops33), .in_last(in_last33), .out_valid(out_valid33),
    .out_ready(out_ready33), .out_sum(out_sum33), .out_count(out_count33),
    .out_ovf(out_ovf33), .dbg_state(dbg_state33)
  );

  typedef struct {
    logic [31:0] a, b, c;
    logic [39:0] sum;
    logic [15:0] cnt;
    logic        ovf;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [95:0] ops3(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    return {c, b, a};
  endfunction

  // Presents one beat and returns #1 after the edge that accepted it.
  task automatic send_beat(input logic [95:0] ops, input logic last);
    int n;
    in_ops   = ops;
    in_last  = last;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("in_ready_wait", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_out();
    int n;
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("out_valid_wait", out_valid, 1);
  endtask

  task automatic expect_result(input string name, input logic [39:0] sum,
                               input logic [15:0] cnt, input logic ovf);
    wait_out();
    check({name, "_sum"}, out_sum, sum);
    check({name, "_count"}, out_count, cnt);
    check({name, "_ovf"}, out_ovf, ovf);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({name, "_valid_drop"}, out_valid, 0);
    check({name, "_ready_back"}, in_ready, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] big;
    logic [39:0] held;

    vecs[0] = '{a: 32'd1,          b: 32'd2,          c: 32'd3,          sum: 40'd6,           cnt: 16'd1, ovf: 1'b0};
    vecs[1] = '{a: 32'd0,          b: 32'd0,          c: 32'd0,          sum: 40'd0,           cnt: 16'd1, ovf: 1'b0};
    vecs[2] = '{a: 32'hFFFFFFFF,   b: 32'd0,          c: 32'd0,          sum: 40'hFFFFFFFF,    cnt: 16'd1, ovf: 1'b0};
    vecs[3] = '{a: 32'hFFFFFFFF,   b: 32'hFFFFFFFF,   c: 32'hFFFFFFFF,   sum: 40'h2FFFFFFFD,   cnt: 16'd1, ovf: 1'b0};
    vecs[4] = '{a: 32'h80000000,   b: 32'h80000000,   c: 32'h80000000,   sum: 40'h180000000,   cnt: 16'd1, ovf: 1'b0};
    vecs[5] = '{a: 32'h12345678,   b: 32'h11111111,   c: 32'h01010101,   sum: 40'h2446688A,    cnt: 16'd1, ovf: 1'b0};

    rst_n = 1'b0;
    in_valid = 1'b0; in_last = 1'b0; in_ops = '0; out_ready = 1'b0;
    in_valid33 = 1'b0; in_last33 = 1'b0; in_ops33 = '0; out_ready33 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_sum", out_sum, 0);
    check("rst_out_count", out_count, 0);
    check("rst_out_ovf", out_ovf, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_state", dbg_state, IDLE);
    check("rst33_out_valid", out_valid33, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single-beat packet with the exact latency profile.
    send_beat(ops3(1, 2, 3), 1'b1);
    check("lat_resolve_valid", out_valid, 0);
    check("lat_resolve_ready", in_ready, 0);
    check("lat_resolve_state", dbg_state, RESOLVE);
    @(posedge clk); #1;
    check("lat_output_valid", out_valid, 1);
    expect_result("one_beat", 40'd6, 16'd1, 1'b0);

    for (int i = 0; i < 6; i++) begin
      send_beat(ops3(vecs[i].a, vecs[i].b, vecs[i].c), 1'b1);
      expect_result($sformatf("vec%0d", i), vecs[i].sum, vecs[i].cnt, vecs[i].ovf);
    end

    // Four full-scale beats: 12 * (2^32 - 1).
    for (int i = 0; i < 4; i++)
      send_beat({3{32'hFFFFFFFF}}, i == 3);
    expect_result("four_beats", 40'hBFFFFFFF4, 16'd4, 1'b0);

    // 86 full-scale beats overflow 2^40; sum wraps and ovf is sticky.
    big = 64'd86 * 64'd3 * 64'hFFFFFFFF;
    for (int i = 0; i < 86; i++)
      send_beat({3{32'hFFFFFFFF}}, i == 85);
    expect_result("wrap40", big[39:0], 16'd86, big >= 64'h10000000000);

    // Narrow accumulator overflows on the first beat.
    check("n33_ready", in_ready33, 1);
    in_ops33 = {3{32'hFFFFFFFF}}; in_last33 = 1'b1; in_valid33 = 1'b1;
    @(posedge clk); #1;
    in_valid33 = 1'b0; in_last33 = 1'b0;
    @(posedge clk); #1;
    check("n33_valid", out_valid33, 1);
    check("n33_sum", out_sum33, 33'h0FFFFFFFD);
    check("n33_ovf", out_ovf33, 1);
    check("n33_count", out_count33, 1);
    out_ready33 = 1'b1;
    @(posedge clk); #1;
    out_ready33 = 1'b0;
    check("n33_valid_drop", out_valid33, 0);

    // Backpressure: result holds, input stalls, offered beats are ignored.
    send_beat(ops3(7, 8, 9), 1'b1);
    wait_out();
    held = out_sum;
    check("bp_first_sum", held, 40'd24);
    for (int i = 0; i < 5; i++) begin
      in_ops = ops3(100, 200, 300); in_last = 1'b1; in_valid = 1'b1;
      @(posedge clk); #1;
      check("bp_sum_stable", out_sum, 40'd24);
      check("bp_in_ready", in_ready, 0);
      check("bp_out_valid", out_valid, 1);
    end
    in_valid = 1'b0; in_last = 1'b0;
    expect_result("bp_release", 40'd24, 16'd1, 1'b0);
    send_beat(ops3(4, 5, 6), 1'b1);
    expect_result("bp_next", 40'd15, 16'd1, 1'b0);

    // Mid-packet reset discards the packet, including a beat offered during reset.
    send_beat(ops3(10, 10, 10), 1'b0);
    send_beat(ops3(10, 10, 10), 1'b0);
    check("mid_state", dbg_state, ACCUM);
    rst_n = 1'b0;
    in_ops = ops3(100, 100, 100); in_valid = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1; in_valid = 1'b0;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_ready", in_ready, 1);
    check("mid_rst_state", dbg_state, IDLE);
    send_beat(ops3(1, 1, 1), 1'b1);
    expect_result("after_rst", 40'd3, 16'd1, 1'b0);

    // Twenty unit beats separated by random bubbles.
    for (int i = 0; i < 20; i++) begin
      int gap;
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) begin
        in_ops = ops3(55, 55, 55);
        @(posedge clk); #1;
        check("bubble_ready", in_ready, 1);
        check("bubble_state", dbg_state, (i == 0) ? IDLE : ACCUM);
      end
      send_beat(ops3(1, 0, 0), i == 19);
    end
    expect_result("bubbles", 40'd20, 16'd20, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
